multicycle_ctrl: RTL

- Control FSM that sequences a shared-ALU, shared-memory MIPS datapath over multiple cycles: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Replaces the single-cycle decoder path. One ALU and one unified memory port are time-multiplexed per state.
- Handles variable-latency memory through a ready handshake with a timeout watchdog.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory port.
// Optional perf counters (cycles_o, instret_o) are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        ir_write_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        fault_o,
  output logic [3:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycles_o,
  output logic [31:0] instret_o
`endif
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_R     = 4'd8,
    WB_I     = 4'd9,
    WB_MEM   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    HALT     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam bit             WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  state_e           after_instr;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;
  logic             in_mem;
  logic             timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'd0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'd0;
    mem_to_reg_o = 2'd0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 3'd0;
    after_instr  = run_i ? FETCH : IDLE;
    in_mem       = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    // The last unanswered wait cycle trips the watchdog and withdraws the request at once.
    timeout_hit  = WDOG_EN && in_mem && !mem_ready_i && (wait_q == LAST_WAIT);

    case (state_q)
      IDLE: if (run_i) state_d = FETCH;
      FETCH: begin
        mem_read_o  = !timeout_hit;
        alu_src_b_o = 2'd1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'd3;
        case (opcode_i)
          OP_RTYPE:       state_d = (funct_i == FN_JR) ? JUMP : EXEC_R;
          OP_ADDI, OP_SLTI: state_d = EXEC_I;
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          default: begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'd2;
        state_d     = WB_R;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = (opcode_i == OP_SLTI) ? 3'd3 : 3'd0;
        state_d     = WB_I;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        state_d     = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        i_or_d_o   = 1'b1;
        mem_read_o = !timeout_hit;
        if (mem_ready_i) state_d = WB_MEM;
      end
      MEM_WR: begin
        i_or_d_o    = 1'b1;
        mem_write_o = !timeout_hit;
        if (mem_ready_i) state_d = after_instr;
      end
      WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 2'd1;
        state_d     = after_instr;
      end
      WB_I: begin
        reg_write_o = 1'b1;
        state_d     = after_instr;
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'd1;
        state_d      = after_instr;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'd1;
        pc_src_o    = 2'd1;
        pc_write_o  = (opcode_i == OP_BEQ) ? zero_i : !zero_i;
        state_d     = after_instr;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = (opcode_i == OP_RTYPE && funct_i == FN_JR) ? 2'd3 : 2'd2;
        if (opcode_i == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'd2;
          mem_to_reg_o = 2'd2;
        end
        state_d = after_instr;
      end
      HALT: state_d = HALT;
      default: begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    endcase

    if (timeout_hit) begin
      state_d = HALT;
      fault_d = 1'b1;
    end

    if (state_d != state_q) wait_d = '0;
    else if (in_mem && !mem_ready_i) wait_d = wait_q + CNT_W'(1);
    else wait_d = wait_q;

    // An instruction aborted by reset must not leave any architectural side effect behind.
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
    end
  end

  assign fault_o = fault_q;
  assign state_o = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] instret_q, instret_d;
  logic        instr_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    instr_done = (state_q == WB_R) || (state_q == WB_I) || (state_q == WB_MEM) ||
                 (state_q == BRANCH) || (state_q == JUMP) ||
                 (state_q == MEM_WR && mem_ready_i);
    cycles_d   = cycles_q + ((state_q != IDLE && state_q != HALT) ? 32'd1 : 32'd0);
    instret_d  = instret_q + (instr_done ? 32'd1 : 32'd0);
  end

  assign cycles_o  = cycles_q;
  assign instret_o = instret_q;
`endif

endmodule
